csrng_cmd_arb: RTL and testbench

- Round-robin command arbiter that shares the single CSRNG core command port among NApps requesters: hardware application interfaces plus the software application.
- Grants one requester at a time and forwards its header word and clen payload words to the core.
- Holds the grant until the core acknowledges completion, then returns ack/status to the granted requester.
- Sits between the application interface ports and csrng_core's command staging logic.

---
 rtl/csrng_cmd_arb.sv | 175 +++++++++++++++++
 tb/tb_csrng_cmd_arb.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csrng_cmd_arb.sv
// csrng_cmd_arb: round-robin arbiter sharing the CSRNG core command port among NApps
// requesters (index NApps-1 is the software application).
//
// A requester is granted in IDLE, its header word and clen payload words are passed through
// to the core, and the grant is held until the core pulses core_ack_i. The ack and status are
// then returned to the granted requester one cycle later.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   enable_i                low blocks new grants; a command in flight completes
//   req_valid_i/req_data_i  per-requester word valid and 32-bit word (requester i at [32*i +: 32])
//   req_ready_o             per-requester word accept
//   core_valid_o/core_data_o/core_app_id_o/core_ready_i   command stream toward the core
//   core_ack_i/core_sts_i   completion pulse and status (1 = error) from the core
//   rsp_ack_o/rsp_sts_o     per-requester completion pulse and held status
//   busy_o                  a command is granted
//   ack_err_o               pulse: core_ack_i arrived while no command was waiting for it
module csrng_cmd_arb #(
  parameter int unsigned NApps = 3,
  parameter int unsigned IdW   = $clog2(NApps)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic [NApps-1:0]      req_valid_i,
  input  logic [NApps*32-1:0]   req_data_i,
  output logic [NApps-1:0]      req_ready_o,
  output logic                  core_valid_o,
  output logic [31:0]           core_data_o,
  output logic [IdW-1:0]        core_app_id_o,
  input  logic                  core_ready_i,
  input  logic                  core_ack_i,
  input  logic                  core_sts_i,
  output logic [NApps-1:0]      rsp_ack_o,
  output logic [NApps-1:0]      rsp_sts_o,
  output logic                  busy_o,
  output logic                  ack_err_o
);

  localparam logic [3:0] MaxClen = 4'd12;

  typedef enum logic [1:0] {
    StIdle,
    StHdr,
    StData,
    StWaitAck
  } state_e;

  state_e           state_q, state_d;
  logic [IdW-1:0]   grant_q, grant_d;
  logic [IdW-1:0]   ptr_q, ptr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [NApps-1:0] rsp_ack_q, rsp_ack_d;
  logic [NApps-1:0] rsp_sts_q, rsp_sts_d;
  logic             ack_err_q, ack_err_d;

  logic [31:0]      req_word [NApps];

  for (genvar i = 0; i < NApps; i++) begin : g_word
    assign req_word[i] = req_data_i[32*i +: 32];
  end

  // Round-robin search starting at the pointer. The wrap is an explicit compare so that
  // non-power-of-two NApps never selects a nonexistent requester.
  logic            arb_found;
  logic [IdW-1:0]  arb_idx;
  int unsigned     cand;

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NApps; k++) begin
      cand = 32'(ptr_q) + k;
      if (cand >= NApps) begin
        cand = cand - NApps;
      end
      if (!arb_found && req_valid_i[cand[IdW-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = cand[IdW-1:0];
      end
    end
  end

  logic        xfer;
  logic [31:0] cur_word;
  logic [3:0]  hdr_clen;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    rsp_ack_d    = '0;
    rsp_sts_d    = rsp_sts_q;
    ack_err_d    = core_ack_i && (state_q != StWaitAck);
    req_ready_o  = '0;
    core_valid_o = 1'b0;
    core_data_o  = '0;
    xfer         = 1'b0;
    cur_word     = req_word[grant_q];
    hdr_clen     = cur_word[7:4];

    unique case (state_q)
      StIdle: begin
        if (enable_i && arb_found) begin
          grant_d = arb_idx;
          state_d = StHdr;
        end
      end

      StHdr, StData: begin
        core_valid_o         = req_valid_i[grant_q];
        core_data_o          = cur_word;
        req_ready_o[grant_q] = core_ready_i;
        xfer                 = req_valid_i[grant_q] && core_ready_i;
        if (xfer) begin
          if (state_q == StHdr) begin
            if (hdr_clen == 4'd0) begin
              cnt_d   = 4'd0;
              state_d = StWaitAck;
            end else begin
              // Oversized clen is clamped; extra words stay unaccepted at the requester.
              cnt_d   = (hdr_clen > MaxClen) ? MaxClen : hdr_clen;
              state_d = StData;
            end
          end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_d = StWaitAck;
            end
          end
        end
      end

      StWaitAck: begin
        if (core_ack_i) begin
          rsp_ack_d[grant_q] = 1'b1;
          rsp_sts_d[grant_q] = core_sts_i;
          ptr_d              = (grant_q == IdW'(NApps - 1)) ? '0 : grant_q + 1'b1;
          state_d            = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      rsp_ack_q <= '0;
      rsp_sts_q <= '0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      rsp_ack_q <= rsp_ack_d;
      rsp_sts_q <= rsp_sts_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign core_app_id_o = grant_q;
  assign rsp_ack_o     = rsp_ack_q;
  assign rsp_sts_o     = rsp_sts_q;
  assign ack_err_o     = ack_err_q;
  assign busy_o        = (state_q != StIdle);

endmodule

// File: tb/tb_csrng_cmd_arb.sv
// Bench for csrng_cmd_arb with NApps=3. Requester drivers stream queued words; expected
// forwarded words and responses are queued as stimulus is issued and a monitor compares them
// whenever the DUT presents a transfer or a response.
module tb_csrng_cmd_arb;
  localparam int unsigned NApps = 3;
  localparam int unsigned IdW   = 2;

  logic                clk;
  logic                rst_i;
  logic                enable_i;
  logic [NApps-1:0]    req_valid_i;
  logic [NApps*32-1:0] req_data_i;
  logic [NApps-1:0]    req_ready_o;
  logic                core_valid_o;
  logic [31:0]         core_data_o;
  logic [IdW-1:0]      core_app_id_o;
  logic                core_ready_i;
  logic                core_ack_i;
  logic                core_sts_i;
  logic [NApps-1:0]    rsp_ack_o;
  logic [NApps-1:0]    rsp_sts_o;
  logic                busy_o;
  logic                ack_err_o;

  csrng_cmd_arb #(
    .NApps(NApps),
    .IdW  (IdW)
  ) u_dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .enable_i     (enable_i),
    .req_valid_i  (req_valid_i),
    .req_data_i   (req_data_i),
    .req_ready_o  (req_ready_o),
    .core_valid_o (core_valid_o),
    .core_data_o  (core_data_o),
    .core_app_id_o(core_app_id_o),
    .core_ready_i (core_ready_i),
    .core_ack_i   (core_ack_i),
    .core_sts_i   (core_sts_i),
    .rsp_ack_o    (rsp_ack_o),
    .rsp_sts_o    (rsp_sts_o),
    .busy_o       (busy_o),
    .ack_err_o    (ack_err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int err_cycle  = -1;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic [33:0] exp_w[$];
  logic [5:0]  exp_a[$];
  logic [2:0]  sts_model = 3'b000;
  logic        toggle_en = 1'b0;
  logic        ready_level = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tx(input int r, input logic [31:0] w);
    case (r)
      0:       q0.push_back(w);
      1:       q1.push_back(w);
      default: q2.push_back(w);
    endcase
  endtask

  task automatic ex(input int r, input logic [31:0] w);
    exp_w.push_back({2'(r), w});
  endtask

  task automatic wait_left(input int n, input string tag);
    int t;
    for (t = 0; t < 300; t++) begin
      @(posedge clk);
      #1;
      if (exp_w.size() <= n) break;
    end
    if (t == 300) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout_%s: %0d words pending, required <= %0d", tag, exp_w.size(), n);
    end
  endtask

  task automatic do_ack(input int r, input logic s);
    sts_model[r] = s;
    exp_a.push_back({3'(1 << r), sts_model});
    core_ack_i = 1'b1;
    core_sts_i = s;
    @(posedge clk);
    #1;
    core_ack_i = 1'b0;
    core_sts_i = 1'b0;
  endtask

  task automatic idle_outputs(input string tag);
    check(tag, {55'd0, core_valid_o, core_app_id_o, rsp_ack_o, rsp_sts_o, busy_o, ack_err_o},
          64'd0);
    check({tag, "_data"}, {32'd0, core_data_o}, 64'd0);
    check({tag, "_ready"}, {61'd0, req_ready_o}, 64'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Ready source: constant level or 1010... toggling.
  initial begin
    core_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      core_ready_i = toggle_en ? ~core_ready_i : ready_level;
    end
  end

  // Requester drivers: present the head of each queue, pop on handshake.
  initial begin
    logic [NApps-1:0] hs;
    req_valid_i = '0;
    req_data_i  = '0;
    forever begin
      @(negedge clk);
      hs = req_valid_i & req_ready_o;
      @(posedge clk);
      #1;
      if (hs[0] && q0.size() > 0) q0.delete(0);
      if (hs[1] && q1.size() > 0) q1.delete(0);
      if (hs[2] && q2.size() > 0) q2.delete(0);
      req_valid_i[0]     = (q0.size() > 0);
      req_valid_i[1]     = (q1.size() > 0);
      req_valid_i[2]     = (q2.size() > 0);
      req_data_i[31:0]   = (q0.size() > 0) ? q0[0] : 32'h0;
      req_data_i[63:32]  = (q1.size() > 0) ? q1[0] : 32'h0;
      req_data_i[95:64]  = (q2.size() > 0) ? q2[0] : 32'h0;
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic [33:0] w;
    logic [5:0]  a;
    logic        rdy_bad;
    forever begin
      @(negedge clk);
      if (core_valid_o && core_ready_i) begin
        if (exp_w.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_word: got id=%0d data=%h, none expected",
                   core_app_id_o, core_data_o);
        end else begin
          w = exp_w.pop_front();
          check("word", {30'd0, core_app_id_o, core_data_o}, {30'd0, w});
        end
      end
      if (rsp_ack_o != '0) begin
        if (exp_a.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_rsp: got ack=%b sts=%b, none expected", rsp_ack_o, rsp_sts_o);
        end else begin
          a = exp_a.pop_front();
          check("rsp_ack_sts", {58'd0, rsp_ack_o, rsp_sts_o}, {58'd0, a});
        end
      end
      check("ack_err", {63'd0, ack_err_o}, {63'd0, (cyc == err_cycle)});
      rdy_bad = ((req_ready_o & ~(3'b001 << core_app_id_o)) != '0) ||
                (!core_ready_i && req_ready_o != '0) ||
                (!busy_o && (req_ready_o != '0 || core_valid_o));
      check("ready_gating", {63'd0, rdy_bad}, 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i      = 1'b1;
    enable_i   = 1'b1;
    core_ack_i = 1'b0;
    core_sts_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    idle_outputs("reset");
    rst_i = 1'b0;

    // Single request from requester 1, clen=2.
    tx(1, 32'hABCD_0021); tx(1, 32'h1111_0001); tx(1, 32'h1111_0002);
    ex(1, 32'hABCD_0021); ex(1, 32'h1111_0001); ex(1, 32'h1111_0002);
    wait_left(0, "single");
    check("single_grant_id", {62'd0, core_app_id_o}, 64'd1);
    check("single_busy", {63'd0, busy_o}, 64'd1);
    do_ack(1, 1'b0);

    // Simultaneous clen=0 commands; pointer is 2, so order is 2,0,1.
    tx(0, 32'h0000_0001); tx(1, 32'h0000_0101); tx(2, 32'h0000_0201);
    ex(2, 32'h0000_0201); ex(0, 32'h0000_0001); ex(1, 32'h0000_0101);
    wait_left(2, "rr_a"); do_ack(2, 1'b1);
    wait_left(1, "rr_b"); do_ack(0, 1'b0);
    wait_left(0, "rr_c"); do_ack(1, 1'b1);
    // Pointer wrapped back to 2.
    tx(0, 32'h0000_0002); tx(2, 32'h0000_0202);
    ex(2, 32'h0000_0202); ex(0, 32'h0000_0002);
    wait_left(1, "rr_d"); do_ack(2, 1'b0);
    wait_left(0, "rr_e"); do_ack(0, 1'b1);

    // Backpressure with clen=4.
    tx(0, 32'h5A5A_0042);
    ex(0, 32'h5A5A_0042);
    for (int k = 0; k < 4; k++) begin
      tx(0, 32'hB000_0000 + 32'(k));
      ex(0, 32'hB000_0000 + 32'(k));
    end
    toggle_en = 1'b1;
    wait_left(0, "bp");
    toggle_en = 1'b0;
    do_ack(0, 1'b0);

    // clen=15 clamps to 12 payload words; the 13th is left for a later grant.
    tx(1, 32'h0000_00F3);
    ex(1, 32'h0000_00F3);
    for (int k = 0; k < 12; k++) begin
      tx(1, 32'hC000_0000 + 32'(k));
      ex(1, 32'hC000_0000 + 32'(k));
    end
    tx(1, 32'h0000_0105);
    wait_left(0, "clamp");
    repeat (4) @(posedge clk);
    #1;
    check("clamp_wait_busy", {63'd0, busy_o}, 64'd1);
    check("clamp_wait_valid", {63'd0, core_valid_o}, 64'd0);
    ex(1, 32'h0000_0105);
    do_ack(1, 1'b0);
    wait_left(0, "leftover");
    do_ack(1, 1'b1);

    // Disabled while idle: no grant.
    enable_i = 1'b0;
    tx(2, 32'h0000_0212); tx(2, 32'h2222_2222);
    repeat (5) @(posedge clk);
    #1;
    check("disabled_busy", {63'd0, busy_o}, 64'd0);
    ex(2, 32'h0000_0212); ex(2, 32'h2222_2222);
    enable_i = 1'b1;
    wait_left(1, "en_hdr");
    // Now in DATA: dropping enable must not affect this command.
    enable_i = 1'b0;
    tx(0, 32'h0000_0003);
    wait_left(0, "en_data");
    do_ack(2, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("disabled_after_cmd_busy", {63'd0, busy_o}, 64'd0);
    ex(0, 32'h0000_0003);
    enable_i = 1'b1;
    wait_left(0, "reenable");
    do_ack(0, 1'b0);

    // Stray ack in IDLE.
    err_cycle  = cyc + 1;
    core_ack_i = 1'b1;
    core_sts_i = 1'b1;
    @(posedge clk);
    #1;
    core_ack_i = 1'b0;
    core_sts_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of DATA.
    tx(2, 32'h0000_0237);
    tx(2, 32'hD000_0000); tx(2, 32'hD000_0001); tx(2, 32'hD000_0002);
    ex(2, 32'h0000_0237); ex(2, 32'hD000_0000);
    wait_left(0, "rst_data");
    check("rst_pre_busy", {63'd0, busy_o}, 64'd1);
    ready_level = 1'b0;
    rst_i       = 1'b1;
    q2.delete();
    @(posedge clk);
    #1;
    rst_i       = 1'b0;
    ready_level = 1'b1;
    #1;
    idle_outputs("rst_mid");
    sts_model = 3'b000;
    // Pointer must be 0 again: requester 0 wins over 2.
    tx(0, 32'h0000_0001); tx(2, 32'h0000_0201);
    ex(0, 32'h0000_0001); ex(2, 32'h0000_0201);
    wait_left(1, "rst_ptr_a"); do_ack(0, 1'b1);
    wait_left(0, "rst_ptr_b"); do_ack(2, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("pending_words", 64'(exp_w.size()), 64'd0);
    check("pending_rsps", 64'(exp_a.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
